// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serialising memory access path.
package mem_pkg;

    // funct3 access-size encodings used by loads and stores
    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    // addr[17:16] value that maps an access to I/O space
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Number of RAM byte transactions needed for an access type
    function automatic logic [2:0] byte_count(input logic [2:0] t);
        case (t)
            TYPE_B, TYPE_BU: return 3'd1;
            TYPE_H, TYPE_HU: return 3'd2;
            default:         return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes.
// Combinational so the store-forwarding path can reuse it.
module mem_load_extend (
    input  logic [31:0] raw,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext
);
    import mem_pkg::*;

    // Pick the extension rule from the funct3 size/sign encoding
    always_comb begin
        ext = raw;
        case (ld_type)
            TYPE_B:  ext = {{24{raw[7]}}, raw[7:0]};
            TYPE_H:  ext = {{16{raw[15]}}, raw[15:0]};
            TYPE_BU: ext = {24'd0, raw[7:0]};
            TYPE_HU: ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Arbitrates icache / LSB word requests onto the 8-bit RAM port,
// one little-endian byte per cycle, and reassembles read results.
module mem_access_unit #(
    parameter int         ADDR_WIDTH = 17,
    parameter logic [1:0] IO_SEL     = mem_pkg::IO_SEL
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    input  logic        lsb_req,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic        lsb_r_nw,
    input  logic [2:0]  lsb_type,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic [31:0] rdata,
    output logic        ic_done,
    output logic        lsb_done,
    output logic        busy
);
    import mem_pkg::*;

    state_e      state_reg;
    logic [1:0]  cnt_reg;
    logic [1:0]  last_reg;
    logic        cap_vld_reg;
    logic        owner_lsb_reg;
    logic [2:0]  type_reg;
    logic [23:0] wdat_reg;
    logic [31:0] asm_reg;
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg;
    logic [31:0] rdata_reg;
    logic        ic_done_reg;
    logic        lsb_done_reg;

    logic [31:0] sel_addr;
    logic [2:0]  sel_type;
    logic [1:0]  sel_last;
    logic        accept;
    logic        io_stall;
    logic [2:0]  rd_next_idx;
    logic        issue_more;
    logic [31:0] asm_next;
    logic [31:0] ext_data;

    // Request selection in IDLE: the LSB always wins over the icache
    always_comb begin
        sel_addr = lsb_req ? lsb_addr : ic_addr;
        sel_type = lsb_req ? lsb_type : TYPE_W;
        sel_last = 2'(byte_count(sel_type) - 3'd1);
        accept   = !flush_in && (lsb_req || ic_req);
    end

    // A UART byte is held back while the TX buffer is full; the select
    // bits sit just above the RAM address field.
    assign io_stall = (mem_a_reg[ADDR_WIDTH -: 2] == IO_SEL) && io_buffer_full;

    // Read pipeline: the byte captured now is cnt_reg, the next address to
    // issue is one ahead of the capture (or index 1 on the very first cycle).
    // Beyond the last byte mem_a parks at 0 so no extra I/O read is issued.
    always_comb begin
        rd_next_idx = cap_vld_reg ? ({1'b0, cnt_reg} + 3'd2) : 3'd1;
        issue_more  = rd_next_idx <= {1'b0, last_reg};
        asm_next    = asm_reg;
        asm_next[8*cnt_reg +: 8] = mem_din;
    end

    mem_load_extend u_ext (
        .raw     (asm_next),
        .ld_type (type_reg),
        .ext     (ext_data)
    );

    // Write strobe is combinational so a full UART buffer blocks the byte
    // in the same cycle it is seen, and rdy_in low always suppresses it.
    assign mem_wr   = rdy_in && (state_reg == ST_WR) && !io_stall;
    assign mem_a    = mem_a_reg;
    assign mem_dout = mem_dout_reg;
    assign rdata    = rdata_reg;
    assign ic_done  = ic_done_reg;
    assign lsb_done = lsb_done_reg;
    assign busy     = (state_reg != ST_IDLE);

    // Main FSM: accept, serialise bytes, capture read data, pulse done
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 2'd0;
            last_reg      <= 2'd0;
            cap_vld_reg   <= 1'b0;
            owner_lsb_reg <= 1'b0;
            type_reg      <= TYPE_W;
            wdat_reg      <= 24'd0;
            asm_reg       <= 32'd0;
            mem_a_reg     <= 32'd0;
            mem_dout_reg  <= 8'd0;
            rdata_reg     <= 32'd0;
            ic_done_reg   <= 1'b0;
            lsb_done_reg  <= 1'b0;
        end else if (rdy_in) begin
            ic_done_reg  <= 1'b0;
            lsb_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    mem_a_reg <= 32'd0;
                    if (accept) begin
                        owner_lsb_reg <= lsb_req;
                        type_reg      <= sel_type;
                        last_reg      <= sel_last;
                        cnt_reg       <= 2'd0;
                        cap_vld_reg   <= 1'b0;
                        asm_reg       <= 32'd0;
                        mem_a_reg     <= sel_addr;
                        if (lsb_req && !lsb_r_nw) begin
                            state_reg    <= ST_WR;
                            mem_dout_reg <= lsb_wdata[7:0];
                            wdat_reg     <= lsb_wdata[31:8];
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (flush_in) begin
                        state_reg <= ST_IDLE;
                        mem_a_reg <= 32'd0;
                    end else begin
                        mem_a_reg   <= issue_more ? (mem_a_reg + 32'd1) : 32'd0;
                        cap_vld_reg <= 1'b1;
                        if (cap_vld_reg) begin
                            asm_reg <= asm_next;
                            if (cnt_reg == last_reg) begin
                                state_reg    <= ST_DONE;
                                rdata_reg    <= ext_data;
                                ic_done_reg  <= !owner_lsb_reg;
                                lsb_done_reg <= owner_lsb_reg;
                            end else begin
                                cnt_reg <= cnt_reg + 2'd1;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (!io_stall) begin
                        if (cnt_reg == last_reg) begin
                            state_reg    <= ST_DONE;
                            mem_a_reg    <= 32'd0;
                            mem_dout_reg <= 8'd0;
                            lsb_done_reg <= 1'b1;
                        end else begin
                            cnt_reg      <= cnt_reg + 2'd1;
                            mem_a_reg    <= mem_a_reg + 32'd1;
                            mem_dout_reg <= wdat_reg[7:0];
                            wdat_reg     <= {8'd0, wdat_reg[23:8]};
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    mem_a_reg <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a cycle-indexed expectation model.
module tb_mem_access_unit;
    localparam int NCYC = 1024;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = 32'd0;
    logic        lsb_req = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_r_nw = 1'b1;
    logic [2:0]  lsb_type = 3'b010;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic [31:0] rdata;
    logic        ic_done;
    logic        lsb_done;
    logic        busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int io_lo = -1, io_hi = -1, rdy_lo = -1, rdy_hi = -1, fl_cyc = -1;
    int st_at = 0, st_len = 0;

    logic [7:0]  ram [0:65535];

    logic [31:0] e_a    [NCYC];
    bit          e_a_v  [NCYC];
    bit          e_wr   [NCYC];
    logic [7:0]  e_dout [NCYC];
    bit          e_dout_v [NCYC];
    bit          e_icd  [NCYC];
    bit          e_lsd  [NCYC];
    logic [31:0] e_rd   [NCYC];
    bit          e_rd_v [NCYC];
    bit          e_busy [NCYC];
    bit          e_busy_v [NCYC];

    mem_access_unit dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .lsb_req        (lsb_req),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_r_nw       (lsb_r_nw),
        .lsb_type       (lsb_type),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .rdata          (rdata),
        .ic_done        (ic_done),
        .lsb_done       (lsb_done),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scheduled side inputs, applied just after each edge
    always @(posedge clk_in) begin
        #1;
        io_buffer_full = (cyc >= io_lo && cyc <= io_hi);
        rdy_in         = !(cyc >= rdy_lo && cyc <= rdy_hi);
        flush_in       = (cyc == fl_cyc);
    end

    // Synchronous RAM: one-cycle read latency, frozen while rdy_in is low
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
            mem_din <= ram[mem_a[15:0]];
        end
    end

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nb(input logic [2:0] t);
        if (t == 3'b010) return 4;
        if (t[0]) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] t, input logic [31:0] raw);
        int v;
        case (t)
            3'b000: begin v = int'(raw[7:0]);  if (v >= 128)   v -= 256;   return 32'(v); end
            3'b001: begin v = int'(raw[15:0]); if (v >= 32768) v -= 65536; return 32'(v); end
            3'b100: return raw % 256;
            3'b101: return raw % 65536;
            default: return raw;
        endcase
    endfunction

    // logical transaction cycle -> absolute cycle, accounting for a rdy stall
    function automatic int rc(input int t0, input int l);
        return t0 + l + ((st_len > 0 && l > st_at) ? st_len : 0);
    endfunction

    function automatic int nrep(input int l);
        return (st_len > 0 && l == st_at) ? st_len + 1 : 1;
    endfunction

    task automatic ex_a(input int t0, input int l, input logic [31:0] v);
        for (int j = 0; j < nrep(l); j++) begin
            e_a[rc(t0, l) + j] = v;
            e_a_v[rc(t0, l) + j] = 1'b1;
        end
    endtask

    task automatic ex_busy(input int t0, input int l, input bit v);
        for (int j = 0; j < nrep(l); j++) begin
            e_busy[rc(t0, l) + j] = v;
            e_busy_v[rc(t0, l) + j] = 1'b1;
        end
    endtask

    // Read of N bytes: addr+k in cycle 1+k, done/rdata in N+2 (or abort at abort_l)
    task automatic model_read(input int t0, input bit lsb, input logic [31:0] addr,
                              input logic [2:0] t, input int abort_l, output int done_c);
        int n;
        logic [31:0] raw;
        logic [31:0] a;
        n = nb(t);
        raw = 32'd0;
        ex_busy(t0, 0, 1'b0);
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            raw = raw | (32'(ram[a[15:0]]) << (8 * k));
            if (abort_l == 0 || 1 + k < abort_l) ex_a(t0, 1 + k, a);
        end
        if (abort_l > 0) begin
            for (int l = 1; l < abort_l; l++) ex_busy(t0, l, 1'b1);
            ex_busy(t0, abort_l, 1'b0);
            ex_a(t0, abort_l, 32'd0);
            done_c = rc(t0, abort_l);
        end else begin
            for (int l = 1; l <= n + 2; l++) ex_busy(t0, l, 1'b1);
            ex_busy(t0, n + 3, 1'b0);
            ex_a(t0, n + 2, 32'd0);
            done_c = rc(t0, n + 2);
            if (lsb) e_lsd[done_c] = 1'b1;
            else     e_icd[done_c] = 1'b1;
            e_rd[done_c] = ext_model(t, raw);
            e_rd_v[done_c] = 1'b1;
        end
    endtask

    // Write of N bytes, one per cycle, I/O bytes held while the buffer is full
    task automatic model_write(input int t0, input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] t, output int done_c);
        int n, k, l, r;
        logic [31:0] a;
        n = nb(t);
        k = 0;
        l = 1;
        e_busy[t0] = 1'b0; e_busy_v[t0] = 1'b1;
        while (k < n && l < 40) begin
            r = t0 + l;
            a = addr + 32'(k);
            e_a[r] = a; e_a_v[r] = 1'b1;
            e_busy[r] = 1'b1; e_busy_v[r] = 1'b1;
            if (!(a[17:16] == 2'b11 && r >= io_lo && r <= io_hi)) begin
                e_wr[r] = 1'b1;
                e_dout[r] = data[8*k +: 8];
                e_dout_v[r] = 1'b1;
                k++;
            end
            l++;
        end
        done_c = t0 + l;
        e_lsd[done_c] = 1'b1;
        e_a[done_c] = 32'd0; e_a_v[done_c] = 1'b1;
        e_busy[done_c] = 1'b1; e_busy_v[done_c] = 1'b1;
        e_busy[done_c + 1] = 1'b0; e_busy_v[done_c + 1] = 1'b1;
    endtask

    // Single compare process: every cycle against the model's expectations
    always @(negedge clk_in) begin
        if (chk_en && cyc < NCYC) begin
            chk("mem_wr", cyc, 32'(mem_wr), 32'(e_wr[cyc]));
            chk("ic_done", cyc, 32'(ic_done), 32'(e_icd[cyc]));
            chk("lsb_done", cyc, 32'(lsb_done), 32'(e_lsd[cyc]));
            if (e_a_v[cyc])    chk("mem_a", cyc, mem_a, e_a[cyc]);
            if (e_dout_v[cyc]) chk("mem_dout", cyc, 32'(mem_dout), 32'(e_dout[cyc]));
            if (e_rd_v[cyc])   chk("rdata", cyc, rdata, e_rd[cyc]);
            if (e_busy_v[cyc]) chk("busy", cyc, 32'(busy), 32'(e_busy[cyc]));
        end
    end

    // Advance to the given cycle, 1 time unit after its starting edge
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic lsb_set(input logic [31:0] a, input logic [2:0] t, input bit r_nw, input logic [31:0] wd);
        lsb_req = 1'b1; lsb_addr = a; lsb_type = t; lsb_r_nw = r_nw; lsb_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, dc, dw, dr;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0104] = 8'hB3; ram[16'h0105] = 8'h85; ram[16'h0106] = 8'h15; ram[16'h0107] = 8'h00;
        ram[16'h0204] = 8'h80;
        ram[16'h0400] = 8'h34; ram[16'h0401] = 8'hF2;
        ram[16'h0500] = 8'h01; ram[16'h0501] = 8'h02; ram[16'h0502] = 8'h03; ram[16'h0503] = 8'h04;

        // reset values
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_mem_a", cyc, mem_a, 32'd0);
        chk("rst_mem_dout", cyc, 32'(mem_dout), 32'd0);
        chk("rst_mem_wr", cyc, 32'(mem_wr), 32'd0);
        chk("rst_rdata", cyc, rdata, 32'd0);
        chk("rst_ic_done", cyc, 32'(ic_done), 32'd0);
        chk("rst_lsb_done", cyc, 32'(lsb_done), 32'd0);
        chk("rst_busy", cyc, 32'(busy), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk_en = 1'b1;
        go(cyc + 2);

        // T1: icache word read at 0x100
        t0 = cyc;
        model_read(t0, 1'b0, 32'h100, 3'b010, 0, dc);
        ic_req = 1'b1; ic_addr = 32'h100;
        go(t0 + 1); #3; chk("t1_mem_a_c1", cyc, mem_a, 32'h100);
        go(t0 + 4); #3; chk("t1_mem_a_c4", cyc, mem_a, 32'h103);
        go(t0 + 6); #3;
        chk("t1_ic_done", cyc, 32'(ic_done), 32'd1);
        chk("t1_rdata", cyc, rdata, 32'h0000_0513);
        go(dc + 1);
        ic_req = 1'b0;

        // T2: LB then LBU at 0x204, back to back from the IDLE cycle
        t0 = cyc;
        model_read(t0, 1'b1, 32'h204, 3'b000, 0, dc);
        lsb_set(32'h204, 3'b000, 1'b1, 32'd0);
        go(t0 + 3); #3; chk("t2_lb_rdata", cyc, rdata, 32'hFFFF_FF80);
        go(dc + 1);
        t0 = cyc;
        model_read(t0, 1'b1, 32'h204, 3'b100, 0, dc);
        lsb_set(32'h204, 3'b100, 1'b1, 32'd0);
        go(t0 + 3); #3; chk("t2_lbu_rdata", cyc, rdata, 32'h0000_0080);
        go(dc + 1);
        t0 = cyc;
        model_read(t0, 1'b1, 32'h400, 3'b001, 0, dc);
        lsb_set(32'h400, 3'b001, 1'b1, 32'd0);
        go(dc + 1);
        t0 = cyc;
        model_read(t0, 1'b1, 32'h400, 3'b101, 0, dc);
        lsb_set(32'h400, 3'b101, 1'b1, 32'd0);
        go(dc + 1);
        lsb_req = 1'b0;
        go(cyc + 2);

        // T3: SH and icache read raised together
        t0 = cyc;
        model_write(t0, 32'h10, 32'h0000_BEEF, 3'b001, dw);
        model_read(dw + 1, 1'b0, 32'h104, 3'b010, 0, dr);
        lsb_set(32'h10, 3'b001, 1'b0, 32'h0000_BEEF);
        ic_req = 1'b1; ic_addr = 32'h104;
        go(t0 + 3); #3; chk("t3_lsb_done", cyc, 32'(lsb_done), 32'd1);
        go(dw + 1);
        lsb_req = 1'b0;
        go(t0 + 5); #3; chk("t3_ic_mem_a", cyc, mem_a, 32'h104);
        go(dr + 1);
        ic_req = 1'b0;
        chk("t3_ram_10", cyc, 32'(ram[16'h0010]), 32'hEF);
        chk("t3_ram_11", cyc, 32'(ram[16'h0011]), 32'hBE);
        go(cyc + 2);

        // T4: SB to UART address with the TX buffer full for cycles 1-3
        t0 = cyc;
        io_lo = t0 + 1; io_hi = t0 + 3;
        model_write(t0, 32'h0003_0000, 32'h0000_0041, 3'b000, dw);
        lsb_set(32'h0003_0000, 3'b000, 1'b0, 32'h0000_0041);
        go(t0 + 2); #3; chk("t4_stall_wr", cyc, 32'(mem_wr), 32'd0);
        go(t0 + 4); #3;
        chk("t4_wr", cyc, 32'(mem_wr), 32'd1);
        chk("t4_dout", cyc, 32'(mem_dout), 32'h41);
        go(t0 + 5); #3; chk("t4_lsb_done", cyc, 32'(lsb_done), 32'd1);
        go(dw + 1);
        lsb_req = 1'b0;
        go(cyc + 2);

        // T5: flush in cycle 2 of an LW abandons it
        t0 = cyc;
        fl_cyc = t0 + 2;
        model_read(t0, 1'b1, 32'h500, 3'b010, 3, dc);
        lsb_set(32'h500, 3'b010, 1'b1, 32'd0);
        go(t0 + 3);
        lsb_req = 1'b0;
        #3; chk("t5_busy_after_flush", cyc, 32'(busy), 32'd0);
        go(t0 + 10);

        // T6: flush during an SW does not stop the store
        t0 = cyc;
        fl_cyc = t0 + 2;
        model_write(t0, 32'h600, 32'h1122_3344, 3'b010, dw);
        lsb_set(32'h600, 3'b010, 1'b0, 32'h1122_3344);
        go(dw); #3; chk("t6_lsb_done", cyc, 32'(lsb_done), 32'd1);
        go(dw + 1);
        lsb_req = 1'b0;
        chk("t6_ram_word", cyc, {ram[16'h0603], ram[16'h0602], ram[16'h0601], ram[16'h0600]}, 32'h1122_3344);
        go(cyc + 2);

        // T7: rdy_in low in cycles 3-5 of an icache word read
        t0 = cyc;
        st_at = 3; st_len = 3;
        rdy_lo = t0 + 3; rdy_hi = t0 + 5;
        model_read(t0, 1'b0, 32'h100, 3'b010, 0, dc);
        ic_req = 1'b1; ic_addr = 32'h100;
        go(t0 + 5); #3; chk("t7_frozen_mem_a", cyc, mem_a, 32'h102);
        go(t0 + 9); #3;
        chk("t7_ic_done", cyc, 32'(ic_done), 32'd1);
        chk("t7_rdata", cyc, rdata, 32'h0000_0513);
        go(dc + 1);
        ic_req = 1'b0;
        st_len = 0;
        go(cyc + 2);

        // T8: reset in the middle of an LW
        t0 = cyc;
        model_read(t0, 1'b1, 32'h100, 3'b010, 3, dc);
        lsb_set(32'h100, 3'b010, 1'b1, 32'd0);
        go(t0 + 2);
        rst_in = 1'b1;
        go(t0 + 3);
        rst_in = 1'b0;
        lsb_req = 1'b0;
        #3;
        chk("t8_busy_after_rst", cyc, 32'(busy), 32'd0);
        chk("t8_mem_a_after_rst", cyc, mem_a, 32'd0);
        go(t0 + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Byte-serialising memory access unit between the 8-bit synchronous `ram` and the two word-level clients: the instruction cache and the load/store buffer. Each cycle it arbitrates one pending request and splits it into 1, 2 or 4 little-endian byte transactions. For reads it reassembles the bytes and sign- or zero-extends the result. It stalls UART writes while `io_buffer_full` is high and drops in-flight reads on a pipeline flush.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM address bits forwarded to `ram.a_in`. `mem_a` stays full 32-bit.
- `IO_SEL`, 2'b11: value of `addr[17:16]` that selects I/O space.

Ports:
- `clk_in` in 1: system clock; one clock domain.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: when low, the block freezes all state and forces `mem_wr=0`.
- `flush_in` in 1: branch-mispredict flush.
- `ic_req` in 1: icache read request, held level-high until `ic_done`.
- `ic_addr` in 32: icache word address.
- `lsb_req` in 1: LSB request, held level-high until `lsb_done`.
- `lsb_addr` in 32: load/store byte address.
- `lsb_wdata` in 32: store data; low bytes are used.
- `lsb_r_nw` in 1: 1 = load, 0 = store.
- `lsb_type` in 3: funct3 encoding. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_din` in 8: RAM read byte, valid one cycle after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write this cycle.
- `io_buffer_full` in 1: UART TX buffer full.
- `rdata` out 32: extended read result; valid while `*_done` is high.
- `ic_done` out 1: one-cycle pulse ending an icache read.
- `lsb_done` out 1: one-cycle pulse ending an LSB load or store.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: accepts a request.
  - RD: issues byte addresses and captures bytes.
  - WR: writes bytes.
  - DONE: one cycle that pulses `*_done`.
- IDLE selection:
  - If `lsb_req` is high, accept the LSB request (LSB has priority).
  - Otherwise, if `ic_req` is high, accept the icache request as a word read (type 010).
  - The accepted request is latched together with an owner bit.
- Byte count: 1 for B/BU, 2 for H/HU, 4 for W.
- Byte k uses address `addr+k`, with 32-bit wrap-around. Alignment is not checked.
- Store byte k is `lsb_wdata[8k+7:8k]`.
- Read byte k is placed in `rdata[8k+7:8k]`.
- Read extension:
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W is passed through unchanged.
- I/O stall: in WR, a byte whose address has `[17:16]==IO_SEL` is not issued while `io_buffer_full` is high. During the stall `mem_wr=0`, the byte counter holds and `mem_a` holds.
- Flush:
  - In RD, `flush_in` returns the unit to IDLE at the next edge with no done pulse.
  - In WR, the store always runs to completion and `lsb_done` still pulses.
  - In IDLE, a flush blocks acceptance that cycle.
- `rdy_in` low: every register holds and the RAM is also disabled. A pending byte capture resumes correctly once `rdy_in` returns.
- Reset values:
  - state = IDLE.
  - `mem_a=0`, `mem_dout=0`, `mem_wr=0`.
  - `rdata=0`, `ic_done=0`, `lsb_done=0`, `busy=0`.
  - Reset mid-transfer abandons the transfer immediately.
- In IDLE and DONE: `mem_wr=0`, `mem_a=0`.

## Timing
- Numbering: cycle 0 is the IDLE cycle in which a request is sampled. All outputs are registered.
- Read of N bytes:
  - `mem_a` = addr+k in cycle 1+k.
  - The byte for address addr+k arrives on `mem_din` in cycle 2+k.
  - DONE, with `rdata` valid, is in cycle N+2.
  - Latency is 3 / 4 / 6 cycles for B / H / W.
- Write of N bytes:
  - `mem_wr=1` in cycles 1..N, plus any I/O stall cycles.
  - DONE is in cycle N+1.
- Requester handshake:
  - The requester must drop its request at the edge ending the DONE cycle.
  - The unit is in IDLE the cycle after DONE and accepts a new request there.
  - Maximum throughput is one word read per 7 cycles.
- If both requests are high in the same IDLE cycle:
  - LSB is served first.
  - The icache is accepted in the first IDLE cycle after `lsb_done`, provided `lsb_req` is low then.

## Structure
- Shared package `mem_pkg`:
  - type encodings TYPE_B/H/W/BU/HU;
  - state enum;
  - IO_SEL;
  - function `byte_count(type)`.
- Sub-module `mem_load_extend` (combinational): takes the 32-bit assembled bytes plus the type and produces the extended `rdata`. It is shared with the LSB store-forwarding path.
- Top level holds the FSM, byte counter (2 bits), latched request registers and the assembly register.

## Test plan
- Icache word read at 0x100, RAM holding bytes 13 05 00 00 → `mem_a` = 0x100..0x103 in cycles 1-4, `ic_done` in cycle 6, `rdata`=0x00000513.
- LSB LB at 0x204 with byte 0x80 → `rdata`=0xFFFFFF80 in cycle 3. LBU at the same address → 0x00000080.
- `ic_req` and `lsb_req` (SH 0xBEEF to 0x10) raised in the same cycle → bytes EF then BE written to 0x10/0x11 in cycles 1-2, `lsb_done` in cycle 3, icache read begins in cycle 5.
- SB 0x41 to 0x30000 with `io_buffer_full` high for cycles 1-3 → `mem_wr` low in cycles 1-3, high in cycle 4 with `mem_dout`=0x41, `lsb_done` in cycle 5.
- `flush_in` in cycle 2 of an LW → no `lsb_done`, IDLE in cycle 3. `flush_in` during an SW → all 4 bytes are written and `lsb_done` pulses.
- `rdy_in` low during cycles 3-5 of a word read → every output frozen during the stall, `ic_done` delayed by 3 cycles, `rdata` correct.
